alu16_op_sequencer: RTL and testbench

Multi-cycle controller for the 16-bit ALU datapath. It accepts one operation at a time over a valid/ready command interface and sequences it. Logic ops (NAND, AND, OR, XOR, NOT) and ADD/SUB complete in one execute cycle. MUL is an iterative shift-add over WIDTH cycles. The result is held in an accumulator, which later commands can select as operand A.

---
 rtl/alu16_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu16_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_op_sequencer.sv
// Multi-cycle sequencer for the 16-bit ALU datapath.
// Accepts one command at a time over valid/ready, runs logic/ADD/SUB in a
// single execute cycle and MUL as a WIDTH-cycle shift-add, then holds the
// result until the consumer takes it. Every result is also written to the
// accumulator, which later commands may select as operand A.
module alu16_op_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic             use_acc,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] in1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_t;

   state_t               state;
   logic [2:0]           op_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     acc;
   logic [WIDTH-1:0]     a_sel;
   logic [WIDTH:0]       exec_res;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   product;
   logic [2*WIDTH-1:0]   product_next;
   logic [WIDTH-1:0]     mplier;
   logic [CNT_W-1:0]     count;

   // Single-cycle ALU result: {carry, value}. MUL never reaches this path.
   function automatic logic [WIDTH:0] alu_eval(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH:0] r;
      case (op)
         3'b000:  r = {1'b0, ~(a & b)};
         3'b001:  r = {1'b0, a & b};
         3'b010:  r = {1'b0, a | b};
         3'b011:  r = {1'b0, a ^ b};
         3'b100:  r = {1'b0, ~a};
         3'b101:  r = {1'b0, a} + {1'b0, b};
         3'b110:  r = {(a < b), a - b};
         default: r = {1'b0, a};
      endcase
      return r;
   endfunction

   assign cmd_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);

   // Operand A source, execute-cycle result and next partial product.
   always_comb begin
      a_sel        = use_acc ? acc : in;
      exec_res     = alu_eval(op_q, a_q, b_q);
      product_next = mplier[0] ? (product + mcand) : product;
   end

   // Control FSM with registered result, accumulator and multiplier state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         out       <= '0;
         carry     <= 1'b0;
         rsp_valid <= 1'b0;
         count     <= '0;
         product   <= '0;
         mcand     <= '0;
         mplier    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  a_q     <= a_sel;
                  b_q     <= in1;
                  mcand   <= {{WIDTH{1'b0}}, a_sel};
                  mplier  <= in1;
                  count   <= '0;
                  product <= '0;
                  state   <= (cmd_op == OP_MUL) ? MULT : EXEC;
               end
            end
            EXEC: begin
               out       <= exec_res[WIDTH-1:0];
               carry     <= exec_res[WIDTH];
               acc       <= exec_res[WIDTH-1:0];
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            MULT: begin
               product <= product_next;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               count   <= count + 1'b1;
               if (count == CNT_LAST) begin
                  out       <= product_next[WIDTH-1:0];
                  carry     <= |product_next[2*WIDTH-1:WIDTH];
                  acc       <= product_next[WIDTH-1:0];
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu16_op_sequencer.sv
// Directed bench for alu16_op_sequencer with an expected-result queue.
module tb_alu16_op_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'b000;
   logic        use_acc = 1'b0;
   logic [15:0] in = 16'h0000;
   logic [15:0] in1 = 16'h0000;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] out;
   logic        carry;
   logic        busy;

   int compared = 0;
   int mismatched = 0;
   logic [16:0] sb[$];
   logic [15:0] model_acc = 16'h0000;

   alu16_op_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .use_acc(use_acc), .in(in), .in1(in1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .out(out),
      .carry(carry), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference result {carry, out} computed with plain integer arithmetic.
   function automatic logic [16:0] model(input logic [2:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
      int unsigned ua;
      int unsigned ub;
      int unsigned r;
      ua = a;
      ub = b;
      case (op)
         3'd0: r = (~(ua & ub)) & 32'hFFFF;
         3'd1: r = ua & ub;
         3'd2: r = ua | ub;
         3'd3: r = ua ^ ub;
         3'd4: r = (~ua) & 32'hFFFF;
         3'd5: r = ua + ub;
         3'd6: r = ((ua - ub) & 32'hFFFF) | ((ua < ub) ? 32'h10000 : 32'h0);
         default: begin
            r = ua * ub;
            r = (r & 32'hFFFF) | (((r >> 16) != 0) ? 32'h10000 : 32'h0);
         end
      endcase
      return r[16:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a command and queue its expected result.
   task automatic drive_cmd(input logic [2:0] op, input logic ua,
                            input logic [15:0] a, input logic [15:0] b);
      logic [16:0] e;
      e = model(op, ua ? model_acc : a, b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      use_acc   = ua;
      in        = a;
      in1       = b;
      sb.push_back(e);
      model_acc = e[15:0];
   endtask

   // Wait until the command is taken, then drop cmd_valid just after that edge.
   task automatic wait_accept(input string tag);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // lat = edge (counted from accept) at which a consumer first samples rsp_valid high.
   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 100);
   endtask

   task automatic check_rsp(input string tag);
      logic [16:0] e;
      if (sb.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_out"}, out, e[15:0]);
         check({tag, "_carry"}, carry, e[16]);
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   // Simple command/response round trip with latency check.
   task automatic run_op(input string tag, input logic [2:0] op, input logic ua,
                         input logic [15:0] a, input logic [15:0] b, input int exp_lat);
      int lat;
      @(negedge clk);
      drive_cmd(op, ua, a, b);
      wait_accept(tag);
      wait_rsp(lat);
      check({tag, "_latency"}, lat, exp_lat);
      check_rsp(tag);
      handshake();
   endtask

   initial begin
      int lat;
      int cyc;
      int last;
      int got;
      int idx;
      bit seen;
      logic [15:0] held_out;
      logic        held_carry;
      logic [15:0] vals [4];
      vals[0] = 16'h0000; vals[1] = 16'h1234; vals[2] = 16'hFFFF; vals[3] = 16'hA5A5;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_out", out, 16'h0000);
      check("rst_carry", carry, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", cmd_ready, 1'b1);

      // 1: NAND with latency and busy tracking
      @(negedge clk);
      drive_cmd(3'd0, 1'b0, 16'h00FF, 16'hFF55);
      wait_accept("t1");
      check("t1_busy_exec", busy, 1'b1);
      wait_rsp(lat);
      check("t1_latency", lat, 2);
      check("t1_busy_done", busy, 1'b1);
      check("t1_out_const", out, 16'hFFAA);
      check_rsp("t1");
      handshake();
      check("t1_busy_after", busy, 1'b0);
      check("t1_rsp_valid_after", rsp_valid, 1'b0);
      check("t1_out_retained", out, 16'hFFAA);

      // 2: ADD with carry, then SUB / XOR from the accumulator
      run_op("t2_add", 3'd5, 1'b0, 16'hFFFF, 16'h0001, 2);
      run_op("t2_sub", 3'd6, 1'b1, 16'h7777, 16'h0001, 2);
      run_op("t2_xor", 3'd3, 1'b1, 16'h0000, 16'h00FF, 2);
      check("t2_xor_const", out, 16'hFF00);

      // 3: iterative multiply
      run_op("t3_mul", 3'd7, 1'b0, 16'h0012, 16'h0034, 17);
      check("t3_mul_const", out, 16'h03A8);
      run_op("t3_mul_ovf", 3'd7, 1'b0, 16'h0100, 16'h0100, 17);
      check("t3_ovf_carry", carry, 1'b1);

      // 4: backpressure with a pending command
      @(negedge clk);
      drive_cmd(3'd5, 1'b0, 16'h1111, 16'h2222);
      wait_accept("t4");
      wait_rsp(lat);
      check("t4_latency", lat, 2);
      held_out = out;
      held_carry = carry;
      check_rsp("t4_add");
      drive_cmd(3'd2, 1'b0, 16'h0F00, 16'h00F0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_out", out, held_out);
         check("t4_hold_carry", carry, held_carry);
         check("t4_hold_valid", rsp_valid, 1'b1);
         check("t4_hold_ready", cmd_ready, 1'b0);
      end
      handshake();
      check("t4_idle_ready", cmd_ready, 1'b1);
      wait_accept("t4_pending");
      wait_rsp(lat);
      check("t4_pending_latency", lat, 2);
      check_rsp("t4_or");
      handshake();

      // 5: reset during multiply aborts it
      @(negedge clk);
      drive_cmd(3'd7, 1'b0, 16'h0003, 16'h0005);
      wait_accept("t5");
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_front());
      model_acc = 16'h0000;
      #1;
      check("t5_ready_after_rst", cmd_ready, 1'b1);
      check("t5_out_cleared", out, 16'h0000);
      check("t5_busy", busy, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("t5_no_response", seen, 1'b0);
      run_op("t5_not_acc", 3'd4, 1'b1, 16'h1234, 16'h5555, 2);
      check("t5_not_const", out, 16'hFFFF);

      // 6: back-to-back NOT stream with rsp_ready held high
      rsp_ready = 1'b1;
      idx = 0; got = 0; cyc = 0; last = -1;
      while (got < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid) begin
            check_rsp("t6_not");
            if (last >= 0) check("t6_spacing", cyc - last, 3);
            last = cyc;
            got++;
         end
         if (cmd_ready && idx < 4) begin
            drive_cmd(3'd4, 1'b0, vals[idx], 16'($urandom));
            idx++;
         end else if (idx >= 4) begin
            cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      check("t6_count", got, 4);
      check("t6_last_const", out, 16'h5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
